// File: rtl/nabp_filter_feeder_pkg.sv
// Shared nabp definitions: sample width, feeder state encoding,
// and the Avalon-ST error constant.
`ifndef NABP_AST_ERROR
`define NABP_AST_ERROR 2'b00
`endif

package nabp_filter_feeder_pkg;

    localparam int kDataLength = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        PAD   = 2'd2,
        DRAIN = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/nabp_filter_feeder_if.sv
// Avalon-ST link between the feeder source and the filter sink.
interface nabp_filter_feeder_if
    import nabp_filter_feeder_pkg::*;
#(
    parameter int DATA_W = kDataLength
);
    logic [DATA_W:0] data;
    logic            valid;
    logic            ready;
    logic [1:0]      error;
    logic            sop;
    logic            eop;

    modport master (
        output data, valid, error, sop, eop,
        input  ready
    );

    modport slave (
        input  data, valid, error, sop, eop,
        output ready
    );
endinterface

// File: rtl/nabp_skid_fifo.sv
// Two-entry FIFO, entry 0 is the head; push and pop may
// happen in the same cycle, including when full.
module nabp_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [1:0]   count
);
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [1:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= din;
                    else if (cnt == 2'd1) e1 <= din;
                    if (cnt != 2'd2) cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0 <= e1;
                    if (cnt != 2'd0) cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                        if (cnt == 2'd0) cnt <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = e0;
    assign empty = (cnt == 2'd0);
    assign full  = (cnt == 2'd2);
    assign count = cnt;
endmodule

// File: rtl/nabp_filter_feeder.sv
// Streams one projection line from RAM into the ramp filter sink,
// followed by PAD_LEN zero beats, through a 2-entry skid FIFO.
module nabp_filter_feeder
    import nabp_filter_feeder_pkg::*;
#(
    parameter int DATA_W      = kDataLength,
    parameter int NUM_SAMPLES = 256,
    parameter int PAD_LEN     = 64,
    parameter int LINE_W      = 8,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LINE_W-1:0] line_idx,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    nabp_filter_feeder_if.master ast
);
    localparam int TOTAL = NUM_SAMPLES + PAD_LEN;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int FW    = DATA_W + 3;

    feeder_state_e     state, state_nx;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt, pad_cnt, xfer_cnt;
    logic              rd_vld, rd_sop, rd_eop;
    logic              issue, pad_push;
    logic              last_issue, last_pad, last_xfer;
    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [1:0]        fifo_cnt, used;
    logic [FW-1:0]     fifo_din, fifo_dout;

    assign last_issue = (issue_cnt == CNT_W'(NUM_SAMPLES - 1));
    assign last_pad   = (pad_cnt == CNT_W'(PAD_LEN - 1));
    assign last_xfer  = (xfer_cnt == CNT_W'(TOTAL - 1));
    assign fifo_pop   = !fifo_empty && ast.ready;

    // Slots committed after this edge; a pop frees one for a new read.
    assign used = fifo_cnt + {1'b0, rd_vld} - {1'b0, fifo_pop};

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        pad_push = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = READ;
            READ: begin
                if (used < 2'd2) begin
                    issue = 1'b1;
                    if (last_issue)
                        state_nx = (PAD_LEN == 0) ? DRAIN : PAD;
                end
            end
            PAD: begin
                // Wait for the last read to land so pads stay behind it.
                if (!rd_vld && (!fifo_full || fifo_pop)) begin
                    pad_push = 1'b1;
                    if (last_pad) state_nx = DRAIN;
                end
            end
            DRAIN: if (fifo_pop && last_xfer) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            pad_cnt   <= '0;
            xfer_cnt  <= '0;
            rd_vld    <= 1'b0;
            rd_sop    <= 1'b0;
            rd_eop    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state  <= state_nx;
            done   <= (state == DRAIN) && (state_nx == IDLE);
            rd_vld <= issue;
            rd_sop <= issue && (issue_cnt == '0);
            rd_eop <= issue && last_issue && (PAD_LEN == 0);
            if (state == IDLE && start) begin
                base      <= ADDR_W'(line_idx) * ADDR_W'(NUM_SAMPLES);
                issue_cnt <= '0;
                pad_cnt   <= '0;
                xfer_cnt  <= '0;
            end else begin
                if (issue)    issue_cnt <= issue_cnt + 1'b1;
                if (pad_push) pad_cnt   <= pad_cnt + 1'b1;
                if (fifo_pop) xfer_cnt  <= xfer_cnt + 1'b1;
            end
        end
    end

    assign fifo_push = rd_vld || pad_push;
    assign fifo_din  = rd_vld ? {1'b0, mem_rd_data, rd_sop, rd_eop}
                              : {{(DATA_W + 1){1'b0}}, 1'b0, last_pad};

    nabp_skid_fifo #(.W(FW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );

    assign busy        = (state != IDLE);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = base + ADDR_W'(issue_cnt);
    assign ast.data    = fifo_dout[FW-1:2];
    assign ast.valid   = !fifo_empty;
    assign ast.sop     = !fifo_empty && fifo_dout[1];
    assign ast.eop     = !fifo_empty && fifo_dout[0];
    assign ast.error   = `NABP_AST_ERROR;
endmodule

// File: tb/tb_nabp_filter_feeder.sv
// Scoreboard bench for nabp_filter_feeder: one instance with padding,
// one with PAD_LEN=0.
module tb_nabp_filter_feeder;

    typedef struct packed {
        logic [16:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_0 = 1'b0;
    logic [7:0]  line_a = '0, line_0 = '0;
    logic        busy_a, done_a, rd_en_a;
    logic        busy_0, done_0, rd_en_0;
    logic [15:0] addr_a, addr_0;
    logic [15:0] rdata_a, rdata_0;
    logic [15:0] ram [0:255];

    nabp_filter_feeder_if #(.DATA_W(16)) if_a ();
    nabp_filter_feeder_if #(.DATA_W(16)) if_0 ();

    nabp_filter_feeder #(
        .DATA_W(16), .NUM_SAMPLES(8), .PAD_LEN(4),
        .LINE_W(8), .ADDR_W(16)
    ) dut (
        .clk(clk), .reset(rst), .start(start_a),
        .line_idx(line_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_en_a), .mem_rd_addr(addr_a),
        .mem_rd_data(rdata_a), .ast(if_a.master)
    );

    nabp_filter_feeder #(
        .DATA_W(16), .NUM_SAMPLES(8), .PAD_LEN(0),
        .LINE_W(8), .ADDR_W(16)
    ) dut0 (
        .clk(clk), .reset(rst), .start(start_0),
        .line_idx(line_0), .busy(busy_0), .done(done_0),
        .mem_rd_en(rd_en_0), .mem_rd_addr(addr_0),
        .mem_rd_data(rdata_0), .ast(if_0.master)
    );

    always @(posedge clk) begin
        if (rd_en_a) rdata_a <= ram[addr_a[7:0]];
        if (rd_en_0) rdata_0 <= ram[addr_0[7:0]];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    beat_t       qa[$], q0[$];
    logic [15:0] aqa[$], aq0[$];

    task automatic push_line(input int line, input bit zpad);
        beat_t b;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 16'(line * 8 + i);
            b.data = {1'b0, ram[a[7:0]]};
            b.sop = (i == 0);
            b.eop = zpad && (i == 7);
            if (zpad) begin q0.push_back(b); aq0.push_back(a); end
            else begin qa.push_back(b); aqa.push_back(a); end
        end
        if (!zpad)
            for (int i = 0; i < 4; i++) begin
                b.data = '0;
                b.sop = 1'b0;
                b.eop = (i == 3);
                qa.push_back(b);
            end
    endtask

    // Ready pattern 1,0,0,1 when enabled; changes just after posedge.
    bit       rdy_mode = 1'b0;
    logic [3:0] pat = 4'b1001;
    initial begin
        int k;
        k = 0;
        if_a.ready = 1'b1;
        if_0.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                if_a.ready = pat[k % 4];
                k++;
            end else begin
                if_a.ready = 1'b1;
            end
        end
    end

    int    beats_a = 0;
    int    ib_a = 0, out_cnt = 0, max_out = 0;
    bit    eop_prev_a = 0, eop_prev_0 = 0, saw_done = 0;
    bit    stall_prev = 0;
    beat_t held;

    always @(negedge clk) begin
        beat_t e;
        bit hs;
        if (rst) begin
            ib_a = 0; out_cnt = 0; eop_prev_a = 0; stall_prev = 0;
        end else begin
            hs = if_a.valid && if_a.ready;
            if (done_a) saw_done = 1;
            if (eop_prev_a || done_a) check("done_a", done_a, eop_prev_a);
            if (stall_prev) begin
                check("stall_valid", if_a.valid, 1);
                check("stall_data", if_a.data, held.data);
                check("stall_sop", if_a.sop, held.sop);
                check("stall_eop", if_a.eop, held.eop);
            end
            if (hs) begin
                beats_a++;
                if (qa.size() == 0) check("beat_unexpected_a", 1, 0);
                else begin
                    e = qa.pop_front();
                    check("beat_data_a", if_a.data, e.data);
                    check("beat_sop_a", if_a.sop, e.sop);
                    check("beat_eop_a", if_a.eop, e.eop);
                end
            end
            if (rd_en_a) begin
                if (aqa.size() == 0) check("rd_unexpected_a", 1, 0);
                else check("rd_addr_a", addr_a, aqa.pop_front());
            end
            out_cnt = out_cnt + int'(rd_en_a) - int'(hs && ib_a < 8);
            if (out_cnt > max_out) max_out = out_cnt;
            if (hs) ib_a = if_a.eop ? 0 : ib_a + 1;
            eop_prev_a = hs && if_a.eop;
            stall_prev = if_a.valid && !if_a.ready;
            held = '{if_a.data, if_a.sop, if_a.eop};
        end
    end

    always @(negedge clk) begin
        beat_t e;
        bit hs;
        if (rst) begin
            eop_prev_0 = 0;
        end else begin
            hs = if_0.valid && if_0.ready;
            if (eop_prev_0 || done_0) check("done_0", done_0, eop_prev_0);
            if (hs) begin
                if (q0.size() == 0) check("beat_unexpected_0", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("beat_data_0", if_0.data, e.data);
                    check("beat_sop_0", if_0.sop, e.sop);
                    check("beat_eop_0", if_0.eop, e.eop);
                end
            end
            if (rd_en_0) begin
                if (aq0.size() == 0) check("rd_unexpected_0", 1, 0);
                else check("rd_addr_0", addr_0, aq0.pop_front());
            end
            eop_prev_0 = hs && if_0.eop;
        end
    end

    task automatic go_a(input logic [7:0] l);
        start_a = 1'b1;
        line_a = l;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_a(input int budget, output int n);
        n = 0;
        while (n < budget && !done_a) begin
            @(negedge clk);
            n++;
        end
        if (!done_a) check("timeout_a", 0, 1);
    endtask

    initial begin
        int n;
        int b0;
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        repeat (3) @(negedge clk);
        check("rst_valid", if_a.valid, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rd_en", rd_en_a, 0);
        check("rst_data", if_a.data, 0);
        check("rst_sop_eop", {if_a.sop, if_a.eop}, 0);
        check("rst_error", if_a.error, 0);
        rst = 1'b0;
        @(negedge clk);

        push_line(3, 0);
        go_a(8'd3);
        check("t1_busy", busy_a, 1);
        wait_a(100, n);
        check("t1_latency", n, 14);
        check("t1_busy_done", busy_a, 0);
        check("t1_q_empty", qa.size(), 0);

        rdy_mode = 1'b1;
        max_out = 0;
        push_line(3, 0);
        go_a(8'd3);
        wait_a(300, n);
        rdy_mode = 1'b0;
        check("t2_q_empty", qa.size(), 0);
        check("t2_max_out_le2", max_out <= 2, 1);

        ram[40] = 16'hFFFF;
        push_line(5, 0);
        go_a(8'd5);
        wait_a(100, n);
        check("t3_q_empty", qa.size(), 0);

        push_line(2, 0);
        go_a(8'd2);
        repeat (4) @(negedge clk);
        go_a(8'd5);
        check("t4_busy_mid", busy_a, 1);
        wait_a(100, n);
        push_line(1, 0);
        go_a(8'd1);
        check("t4_busy_line1", busy_a, 1);
        wait_a(100, n);
        check("t4_latency", n, 14);
        check("t4_q_empty", qa.size() + aqa.size(), 0);

        push_line(3, 0);
        b0 = beats_a;
        go_a(8'd3);
        n = 0;
        while (beats_a - b0 < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        qa.delete();
        aqa.delete();
        saw_done = 0;
        check("t5_valid", if_a.valid, 0);
        check("t5_busy", busy_a, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_no_done", saw_done, 0);
        push_line(4, 0);
        go_a(8'd4);
        wait_a(100, n);
        check("t5_latency", n, 14);
        check("t5_q_empty", qa.size(), 0);

        push_line(6, 1);
        start_0 = 1'b1;
        line_0 = 8'd6;
        @(negedge clk);
        start_0 = 1'b0;
        n = 0;
        while (n < 100 && !done_0) begin
            @(negedge clk);
            n++;
        end
        if (!done_0) check("timeout_0", 0, 1);
        check("t6_latency", n, 10);
        check("t6_busy", busy_0, 0);
        check("t6_q_empty", q0.size() + aq0.size(), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
